// File: rtl/vram_write_queue_m.sv
// vram_write_queue_m
//   CPU-side writer for the GPU VRAM port. CPU writes (address + data) are
//   buffered in a FIFO and drained onto the registered GPU VRAM bus, one per
//   clock, only while the video timing 'writable' window is open.
//
// Ports
//   clk           pixel clock, the only clock
//   rst           synchronous active-high reset (flushes the queue)
//   cpu_wr_valid  CPU write request
//   cpu_wr_ready  queue can accept; a push happens on valid & ready
//   cpu_addr      VRAM address of the request
//   cpu_data      VRAM data of the request
//   writable      VRAM may be written this cycle
//   vram_address  registered address to the GPU
//   vram_data     registered data to the GPU
//   vram_we       registered write strobe to the GPU
//   fifo_level    number of entries currently queued
//   frame_done    one-cycle pulse: queue emptied inside a writable window
//
// Optional build macro VRAM_WRITE_QUEUE_STATS_EN adds:
//   drop_cycles   saturating count of cycles with cpu_wr_valid & !cpu_wr_ready
//   peak_level    highest fifo_level observed
//
// ADDR_W defaults to `VRAM_ADDR_WIDTH, which falls back to 15 when undefined.

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 15
`endif

module vram_write_queue_m #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = `VRAM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_wr_valid,
  output logic                      cpu_wr_ready,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [7:0]                cpu_data,
  input  logic                      writable,
  output logic [ADDR_W-1:0]         vram_address,
  output logic [7:0]                vram_data,
  output logic                      vram_we,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      frame_done
`ifdef VRAM_WRITE_QUEUE_STATS_EN
  ,
  output logic [15:0]               drop_cycles,
  output logic [$clog2(DEPTH):0]    peak_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [ADDR_W+7:0]   mem [DEPTH];
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                frame_done_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // Ready depends only on the registered pointers, so a same-cycle pop can
  // never open the door for a push at full.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cpu_wr_ready = !full;
  assign push         = cpu_wr_valid && !full;
  assign fifo_level   = wr_ptr - rd_ptr;

  // Drain controller. The entry edge out of IDLE already pops the head so a
  // freshly pushed entry reaches the GPU bus one edge after its push. Losing
  // the window always wins over the empty exit, so frame_done only fires when
  // the queue ran dry while VRAM was still writable.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (writable && !empty) begin
          pop     = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!writable) begin
          state_d = IDLE;
        end else if (empty) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
    endcase
  end

  // State, pointers and the registered GPU bus. Address and data only move
  // on a pop and otherwise hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      vram_we      <= 1'b0;
      vram_address <= '0;
      vram_data    <= '0;
      frame_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= frame_done_d;
      vram_we    <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr                    <= rd_ptr + 1'b1;
        {vram_address, vram_data} <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cpu_addr, cpu_data};
    end
  end

`ifdef VRAM_WRITE_QUEUE_STATS_EN
  // Saturating statistics; they stick at their maximum rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cycles <= '0;
      peak_level  <= '0;
    end else begin
      if (cpu_wr_valid && !cpu_wr_ready && (drop_cycles != 16'hFFFF)) begin
        drop_cycles <= drop_cycles + 16'd1;
      end
      if (fifo_level > peak_level) begin
        peak_level <= fifo_level;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_write_queue_m.sv
// tb_vram_write_queue_m
//   Directed self-checking bench for vram_write_queue_m with DEPTH=64 and a
//   15-bit VRAM address. Inputs change 1 time unit after each rising edge and
//   outputs are sampled at that same point.

module tb_vram_write_queue_m;

  localparam int AW    = 15;
  localparam int DEPTH = 64;

  logic          clk;
  logic          rst;
  logic          cpu_wr_valid;
  logic          cpu_wr_ready;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          writable;
  logic [AW-1:0] vram_address;
  logic [7:0]    vram_data;
  logic          vram_we;
  logic [6:0]    fifo_level;
  logic          frame_done;
`ifdef VRAM_WRITE_QUEUE_STATS_EN
  logic [15:0]   drop_cycles;
  logic [6:0]    peak_level;
`endif

  int total = 0;
  int bad   = 0;

  vram_write_queue_m #(
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_wr_valid(cpu_wr_valid),
    .cpu_wr_ready(cpu_wr_ready),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .writable    (writable),
    .vram_address(vram_address),
    .vram_data   (vram_data),
    .vram_we     (vram_we),
    .fifo_level  (fifo_level),
    .frame_done  (frame_done)
`ifdef VRAM_WRITE_QUEUE_STATS_EN
    ,
    .drop_cycles (drop_cycles),
    .peak_level  (peak_level)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one entry while the queue has room.
  task automatic push_one(input logic [AW-1:0] a, input logic [7:0] d);
    cpu_wr_valid = 1'b1;
    cpu_addr     = a;
    cpu_data     = d;
    step();
    cpu_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if (vram_we !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_we got=%0b expected=0", vram_we);
    end
    total++;
    if (fifo_level !== 7'd0) begin
      bad++; $display("[TB] FAIL reset_level got=%0d expected=0", fifo_level);
    end
    total++;
    if (cpu_wr_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_ready got=%0b expected=1", cpu_wr_ready);
    end
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_frame_done got=%0b expected=0", frame_done);
    end
    total++;
    if ({vram_address, vram_data} !== {15'h0, 8'h00}) begin
      bad++; $display("[TB] FAIL reset_bus got=%0h/%0h expected=0/0", vram_address, vram_data);
    end
  endtask

  // Three writes, one duplicate address, drained back to back.
  task automatic test_order();
    logic [AW-1:0] ea [3];
    logic [7:0]    ed [3];
    ea[0] = 15'h010; ed[0] = 8'hAA;
    ea[1] = 15'h011; ed[1] = 8'hBB;
    ea[2] = 15'h010; ed[2] = 8'hCC;
    writable = 1'b0;
    for (int i = 0; i < 3; i++) push_one(ea[i], ed[i]);
    total++;
    if (fifo_level !== 7'd3 || vram_we !== 1'b0) begin
      bad++; $display("[TB] FAIL order_queued level=%0d we=%0b expected level=3 we=0", fifo_level, vram_we);
    end
    writable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (vram_we !== 1'b1 || vram_address !== ea[i] || vram_data !== ed[i] || frame_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL order_write%0d got we=%0b %0h:%0h fd=%0b expected we=1 %0h:%0h fd=0",
                 i, vram_we, vram_address, vram_data, frame_done, ea[i], ed[i]);
      end
    end
    step();
    total++;
    if (frame_done !== 1'b1 || vram_we !== 1'b0 || fifo_level !== 7'd0) begin
      bad++; $display("[TB] FAIL order_done got fd=%0b we=%0b level=%0d expected fd=1 we=0 level=0", frame_done, vram_we, fifo_level);
    end
    step();
    total++;
    if (frame_done !== 1'b0 || vram_address !== 15'h010 || vram_data !== 8'hCC) begin
      bad++; $display("[TB] FAIL order_hold got fd=%0b %0h:%0h expected fd=0 10:cc", frame_done, vram_address, vram_data);
    end
    writable = 1'b0;
  endtask

  // Reset while a 10-entry drain is in progress.
  task automatic test_mid_reset();
    writable = 1'b0;
    for (int i = 0; i < 10; i++) push_one(15'(12'h200 + i), 8'(i));
    writable = 1'b1;
    step();
    step();
    total++;
    if (vram_we !== 1'b1 || vram_address !== 15'h201) begin
      bad++; $display("[TB] FAIL midrst_draining got we=%0b addr=%0h expected we=1 addr=201", vram_we, vram_address);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (vram_we !== 1'b0 || fifo_level !== 7'd0 || cpu_wr_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_state got we=%0b level=%0d ready=%0b expected 0/0/1", vram_we, fifo_level, cpu_wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (vram_we !== 1'b0 || frame_done !== 1'b0) begin
        bad++; $display("[TB] FAIL midrst_quiet%0d got we=%0b fd=%0b expected 0/0", i, vram_we, frame_done);
      end
    end
    writable = 1'b0;
  endtask

  // Window closes after five writes; the rest carries over.
  task automatic test_partial();
    writable = 1'b0;
    for (int i = 0; i < 20; i++) push_one(15'(12'h300 + i), 8'(8'h40 + i));
    writable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (vram_we !== 1'b1 || vram_address !== 15'(12'h300 + i) || vram_data !== 8'(8'h40 + i)) begin
        bad++; $display("[TB] FAIL partial_w%0d got we=%0b %0h:%0h expected we=1 %0h:%0h",
                        i, vram_we, vram_address, vram_data, 12'h300 + i, 8'h40 + i);
      end
    end
    writable = 1'b0;
    step();
    total++;
    if (vram_we !== 1'b0 || fifo_level !== 7'd15 || frame_done !== 1'b0) begin
      bad++; $display("[TB] FAIL partial_closed got we=%0b level=%0d fd=%0b expected 0/15/0", vram_we, fifo_level, frame_done);
    end
    step();
    step();
    total++;
    if (vram_we !== 1'b0 || fifo_level !== 7'd15 || vram_address !== 15'h304) begin
      bad++; $display("[TB] FAIL partial_hold got we=%0b level=%0d addr=%0h expected 0/15/304", vram_we, fifo_level, vram_address);
    end
    writable = 1'b1;
    for (int i = 5; i < 20; i++) begin
      step();
      total++;
      if (vram_we !== 1'b1 || vram_address !== 15'(12'h300 + i) || vram_data !== 8'(8'h40 + i)) begin
        bad++; $display("[TB] FAIL partial_r%0d got we=%0b %0h:%0h expected we=1 %0h:%0h",
                        i, vram_we, vram_address, vram_data, 12'h300 + i, 8'h40 + i);
      end
    end
    step();
    total++;
    if (frame_done !== 1'b1 || fifo_level !== 7'd0) begin
      bad++; $display("[TB] FAIL partial_done got fd=%0b level=%0d expected 1/0", frame_done, fifo_level);
    end
    writable = 1'b0;
  endtask

  // Pushes every cycle with the window open: minimum latency streaming.
  task automatic test_back_to_back();
    writable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cpu_wr_valid = 1'b1;
      cpu_addr     = 15'(12'h100 + k);
      cpu_data     = 8'(8'h80 + k);
      step();
      total++;
      if (fifo_level !== 7'd1) begin
        bad++; $display("[TB] FAIL b2b_level%0d got=%0d expected=1", k, fifo_level);
      end
      total++;
      if (k == 0) begin
        if (vram_we !== 1'b0) begin
          bad++; $display("[TB] FAIL b2b_first got we=%0b expected=0", vram_we);
        end
      end else if (vram_we !== 1'b1 || vram_address !== 15'(12'h100 + k - 1) || vram_data !== 8'(8'h80 + k - 1)) begin
        bad++; $display("[TB] FAIL b2b_w%0d got we=%0b %0h:%0h expected we=1 %0h:%0h",
                        k, vram_we, vram_address, vram_data, 12'h100 + k - 1, 8'h80 + k - 1);
      end
    end
    cpu_wr_valid = 1'b0;
    step();
    total++;
    if (vram_we !== 1'b1 || vram_address !== 15'h107 || fifo_level !== 7'd0 || frame_done !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_last got we=%0b addr=%0h level=%0d fd=%0b expected 1/107/0/0",
                      vram_we, vram_address, fifo_level, frame_done);
    end
    step();
    total++;
    if (frame_done !== 1'b1 || vram_we !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_done got fd=%0b we=%0b expected 1/0", frame_done, vram_we);
    end
    writable = 1'b0;
  endtask

  // Fill to DEPTH, stall, then push-at-full during a pop.
  task automatic test_full();
    writable     = 1'b0;
    cpu_wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_addr = 15'(i);
      cpu_data = 8'(i);
      step();
    end
    total++;
    if (cpu_wr_ready !== 1'b0 || fifo_level !== 7'd64) begin
      bad++; $display("[TB] FAIL full_reached got ready=%0b level=%0d expected 0/64", cpu_wr_ready, fifo_level);
    end
    cpu_addr = 15'h3FF;
    cpu_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (fifo_level !== 7'd64 || cpu_wr_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL full_stall%0d got level=%0d ready=%0b expected 64/0", i, fifo_level, cpu_wr_ready);
      end
    end
`ifdef VRAM_WRITE_QUEUE_STATS_EN
    total++;
    if (drop_cycles !== 16'd3 || peak_level !== 7'd64) begin
      bad++; $display("[TB] FAIL stats got drops=%0d peak=%0d expected 3/64", drop_cycles, peak_level);
    end
`endif
    writable = 1'b1;
    step();
    cpu_wr_valid = 1'b0;
    total++;
    if (fifo_level !== 7'd63 || vram_we !== 1'b1 || vram_address !== 15'h000 || cpu_wr_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL full_pushpop got level=%0d we=%0b addr=%0h ready=%0b expected 63/1/0/1",
                      fifo_level, vram_we, vram_address, cpu_wr_ready);
    end
    for (int i = 1; i < DEPTH; i++) begin
      step();
      total++;
      if (vram_we !== 1'b1 || vram_address !== 15'(i) || vram_data !== 8'(i)) begin
        bad++; $display("[TB] FAIL full_drain%0d got we=%0b %0h:%0h expected we=1 %0h:%0h",
                        i, vram_we, vram_address, vram_data, i, i);
      end
    end
    step();
    total++;
    if (frame_done !== 1'b1 || fifo_level !== 7'd0 || vram_we !== 1'b0) begin
      bad++; $display("[TB] FAIL full_done got fd=%0b level=%0d we=%0b expected 1/0/0", frame_done, fifo_level, vram_we);
    end
    writable = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    cpu_wr_valid = 1'b0;
    cpu_addr     = '0;
    cpu_data     = '0;
    writable     = 1'b0;
    test_reset();
    test_order();
    test_mid_reset();
    test_partial();
    test_back_to_back();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
